csr_unit: RTL and testbench

- Parametrised machine-mode CSR file and trap controller; successor to the minimal mstatus/mtvec/mepc/mcause register block.
- Read port in decode. Write, trap-entry and mret ports in writeback.
- Adds:
  - internal read-modify-write for CSRRW/CSRRS/CSRRC;
  - mie/mip/mscratch/mtval;
  - interrupt request generation;
  - vectored mtvec;
  - registered redirect to the fetch stage;
  - optional 64-bit cycle/instret counters.

---
 rtl/csr_unit.sv | 214 +++++++++++++++++++++
 tb/tb_csr_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// ============================================================================
// Module   : csr_unit
// Purpose  : Machine-mode CSR file, trap/mret controller and interrupt request
//            logic. The `CSR_COUNTERS_EN macro adds 64-bit mcycle/minstret.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0,
  parameter int unsigned     HART_ID     = 0,
  parameter logic [XLEN-1:0] MISA_VAL    = 32'h40000100
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic [11:0]     rd_addr_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_illegal_o,
  input  logic            wr_en_i,
  input  logic [1:0]      wr_op_i,
  input  logic [11:0]     wr_addr_i,
  input  logic [XLEN-1:0] wr_src_i,
  input  logic            trap_i,
  input  logic            trap_irq_i,
  input  logic [3:0]      trap_code_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_val_i,
  input  logic            mret_i,
  input  logic            retire_i,
  input  logic            irq_ext_i,
  input  logic            irq_timer_i,
  output logic            irq_req_o,
  output logic [3:0]      irq_code_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam logic [1:0]      OP_RW      = 2'b01;
  localparam logic [1:0]      OP_RS      = 2'b10;
  localparam logic [1:0]      OP_RC      = 2'b11;
  localparam logic [XLEN-1:0] MIE_MASK   = XLEN'(32'h0000_0888);
  localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(32'h2);
  localparam logic [XLEN-1:0] MEPC_MASK  = ~XLEN'(32'h3);

  logic            mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0] mip_w, pending_w, wr_old_w, wr_new_w, vec_base_w;
  logic            wr_ill_w, wr_eff_w;

`ifdef CSR_COUNTERS_EN
  logic [2*XLEN-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
`endif

  assign mip_w = (XLEN'(irq_ext_i) << 11) | (XLEN'(irq_timer_i) << 7);

  function automatic void csr_read(input logic [11:0] a, output logic [XLEN-1:0] d,
                                   output logic ill);
    d   = '0;
    ill = 1'b0;
    case (a)
      12'h300: begin
        d[12:11] = 2'b11;
        d[7]     = mst_mpie_q;
        d[3]     = mst_mie_q;
      end
      12'h301: d = MISA_VAL;
      12'h304: d = mie_q;
      12'h305: d = mtvec_q;
      12'h340: d = mscratch_q;
      12'h341: d = mepc_q;
      12'h342: d = mcause_q;
      12'h343: d = mtval_q;
      12'h344: d = mip_w;
      12'hF14: d = XLEN'(HART_ID);
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: d = mcycle_q[XLEN-1:0];
      12'hB80, 12'hC80: d = mcycle_q[2*XLEN-1:XLEN];
      12'hB02, 12'hC02: d = minstret_q[XLEN-1:0];
      12'hB82, 12'hC82: d = minstret_q[2*XLEN-1:XLEN];
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  always_comb csr_read(rd_addr_i, rd_data_o, rd_illegal_o);
  always_comb csr_read(wr_addr_i, wr_old_w, wr_ill_w);

  // Lower-priority events are dropped whenever a trap or mret commits.
  assign wr_eff_w = wr_en_i && (wr_op_i != 2'b00) && !wr_ill_w && !trap_i && !mret_i;

  always_comb begin
    case (wr_op_i)
      OP_RW:   wr_new_w = wr_src_i;
      OP_RS:   wr_new_w = wr_old_w | wr_src_i;
      OP_RC:   wr_new_w = wr_old_w & ~wr_src_i;
      default: wr_new_w = wr_old_w;
    endcase
  end

  assign pending_w  = mip_w & mie_q;
  assign irq_req_o  = mst_mie_q && (pending_w != '0);
  assign irq_code_o = pending_w[11] ? 4'd11 : (pending_w[7] ? 4'd7 : 4'd0);
  assign vec_base_w = {mtvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    mst_mie_d     = mst_mie_q;
    mst_mpie_d    = mst_mpie_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    if (trap_i) begin
      mepc_d     = trap_pc_i & MEPC_MASK;
      mcause_d   = {trap_irq_i, {(XLEN-5){1'b0}}, trap_code_i};
      mtval_d    = trap_val_i;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
      redirect_d = 1'b1;
      if (trap_irq_i && (mtvec_q[1:0] == 2'b01))
        redirect_pc_d = vec_base_w + XLEN'({trap_code_i, 2'b00});
      else
        redirect_pc_d = vec_base_w;
    end else if (mret_i) begin
      mst_mie_d     = mst_mpie_q;
      mst_mpie_d    = 1'b1;
      redirect_d    = 1'b1;
      redirect_pc_d = mepc_q;
    end else if (wr_eff_w) begin
      case (wr_addr_i)
        12'h300: begin
          mst_mie_d  = wr_new_w[3];
          mst_mpie_d = wr_new_w[7];
        end
        12'h304: mie_d      = wr_new_w & MIE_MASK;
        12'h305: mtvec_d    = wr_new_w & MTVEC_MASK;
        12'h340: mscratch_d = wr_new_w;
        12'h341: mepc_d     = wr_new_w & MEPC_MASK;
        12'h342: mcause_d   = wr_new_w;
        12'h343: mtval_d    = wr_new_w;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie_q     <= 1'b0;
      mst_mpie_q    <= 1'b0;
      mie_q         <= '0;
      mtvec_q       <= MTVEC_RESET & MTVEC_MASK;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      mst_mie_q     <= mst_mie_d;
      mst_mpie_q    <= mst_mpie_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;

`ifdef CSR_COUNTERS_EN
  // A software write to either half replaces it and suppresses that tick.
  always_comb begin
    mcycle_d   = mcycle_q + 1'b1;
    minstret_d = retire_i ? minstret_q + 1'b1 : minstret_q;
    if (wr_eff_w) begin
      case (wr_addr_i)
        12'hB00: mcycle_d   = {mcycle_q[2*XLEN-1:XLEN], wr_new_w};
        12'hB80: mcycle_d   = {wr_new_w, mcycle_q[XLEN-1:0]};
        12'hB02: minstret_d = {minstret_q[2*XLEN-1:XLEN], wr_new_w};
        12'hB82: minstret_d = {wr_new_w, minstret_q[XLEN-1:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  logic unused_w;
  assign unused_w = retire_i;
`endif

endmodule

`default_nettype wire

// File: tb/tb_csr_unit.sv
// ============================================================================
// Module   : tb_csr_unit
// Purpose  : Directed self-checking bench for csr_unit (counter checks when
//            CSR_COUNTERS_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] rd_addr_i;
  logic [31:0] rd_data_o;
  logic        rd_illegal_o;
  logic        wr_en_i;
  logic [1:0]  wr_op_i;
  logic [11:0] wr_addr_i;
  logic [31:0] wr_src_i;
  logic        trap_i, trap_irq_i;
  logic [3:0]  trap_code_i;
  logic [31:0] trap_pc_i, trap_val_i;
  logic        mret_i, retire_i, irq_ext_i, irq_timer_i;
  logic        irq_req_o;
  logic [3:0]  irq_code_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  csr_unit dut (
    .clk_i(clk), .rst_n(rst_n),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_illegal_o(rd_illegal_o),
    .wr_en_i(wr_en_i), .wr_op_i(wr_op_i), .wr_addr_i(wr_addr_i), .wr_src_i(wr_src_i),
    .trap_i(trap_i), .trap_irq_i(trap_irq_i), .trap_code_i(trap_code_i),
    .trap_pc_i(trap_pc_i), .trap_val_i(trap_val_i), .mret_i(mret_i),
    .retire_i(retire_i), .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
    .irq_req_o(irq_req_o), .irq_code_o(irq_code_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    rd_addr_i = a;
    #1;
    chk(tag, rd_data_o, exp);
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] src);
    wr_en_i = 1'b1; wr_op_i = op; wr_addr_i = a; wr_src_i = src;
    tick();
    wr_en_i = 1'b0; wr_op_i = 2'b00;
  endtask

  task automatic trap(input logic irq, input logic [3:0] code, input logic [31:0] pc,
                      input logic [31:0] val);
    trap_i = 1'b1; trap_irq_i = irq; trap_code_i = code; trap_pc_i = pc; trap_val_i = val;
    tick();
    trap_i = 1'b0; trap_irq_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rd_addr_i = '0; wr_en_i = 0; wr_op_i = 0; wr_addr_i = '0; wr_src_i = '0;
    trap_i = 0; trap_irq_i = 0; trap_code_i = '0; trap_pc_i = '0; trap_val_i = '0;
    mret_i = 0; retire_i = 0; irq_ext_i = 0; irq_timer_i = 0;
    tick(); tick();
    chk("rst_redirect", {31'b0, redirect_o}, 32'h0);
    chk("rst_redirect_pc", redirect_pc_o, 32'h0);
    rst_n = 1'b1;
    tick();

    // reset values and unimplemented address
    rd(12'h300, 32'h0000_1800, "rst_mstatus");
    rd(12'h305, 32'h0000_0000, "rst_mtvec");
    rd(12'h7C0, 32'h0, "illegal_data");
    chk("illegal_flag", {31'b0, rd_illegal_o}, 32'h1);
    rd(12'h301, 32'h4000_0100, "misa");
    chk("misa_legal", {31'b0, rd_illegal_o}, 32'h0);
    irq_ext_i = 1'b1;
    rd(12'h344, 32'h0000_0800, "mip_meip");
    irq_ext_i = 1'b0;
    tick();

    // read-modify-write and masks
    wr(2'b01, 12'h340, 32'hF0F0_F0F0);
    wr(2'b11, 12'h340, 32'h0000_00F0);
    rd(12'h340, 32'hF0F0_F000, "mscratch_rc");
    wr(2'b10, 12'h300, 32'h0000_0008);
    rd(12'h300, 32'h0000_1808, "mstatus_rs");
    wr(2'b01, 12'h304, 32'hFFFF_FFFF);
    rd(12'h304, 32'h0000_0888, "mie_mask");
    wr(2'b01, 12'h304, 32'h0);
    wr(2'b01, 12'h301, 32'h0);
    rd(12'h301, 32'h4000_0100, "misa_ro");

    // synchronous exception trap
    wr(2'b01, 12'h305, 32'h0000_0102);
    rd(12'h305, 32'h0000_0100, "mtvec_bit1");
    trap(1'b0, 4'd11, 32'h0000_2006, 32'h0000_0055);
    chk("trap_redirect", {31'b0, redirect_o}, 32'h1);
    chk("trap_target", redirect_pc_o, 32'h0000_0100);
    rd(12'h341, 32'h0000_2004, "trap_mepc");
    rd(12'h342, 32'h0000_000B, "trap_mcause");
    rd(12'h343, 32'h0000_0055, "trap_mtval");
    rd(12'h300, 32'h0000_1880, "trap_mstatus");
    tick();
    chk("redirect_one_cycle", {31'b0, redirect_o}, 32'h0);

    // vectored interrupt then mret
    wr(2'b01, 12'h305, 32'h0000_0201);
    wr(2'b01, 12'h304, 32'h0000_0080);
    irq_timer_i = 1'b1;
    #1;
    chk("irq_masked_by_mie", {31'b0, irq_req_o}, 32'h0);
    wr(2'b10, 12'h300, 32'h0000_0008);
    chk("irq_req", {31'b0, irq_req_o}, 32'h1);
    chk("irq_code", {28'b0, irq_code_o}, 32'h7);
    trap(1'b1, 4'd7, 32'h0000_3000, 32'h0);
    chk("vec_redirect", {31'b0, redirect_o}, 32'h1);
    chk("vec_target", redirect_pc_o, 32'h0000_021C);
    rd(12'h342, 32'h8000_0007, "vec_mcause");
    chk("irq_req_after_trap", {31'b0, irq_req_o}, 32'h0);
    irq_timer_i = 1'b0;
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    chk("mret_redirect", {31'b0, redirect_o}, 32'h1);
    chk("mret_target", redirect_pc_o, 32'h0000_3000);
    rd(12'h300, 32'h0000_1888, "mret_mstatus");

    // trap, mret and write in one cycle: trap wins
    mret_i = 1'b1;
    wr_en_i = 1'b1; wr_op_i = 2'b01; wr_addr_i = 12'h340; wr_src_i = 32'h5;
    trap(1'b0, 4'd2, 32'h0000_4000, 32'h0);
    mret_i = 1'b0; wr_en_i = 1'b0; wr_op_i = 2'b00;
    chk("coll_redirect", {31'b0, redirect_o}, 32'h1);
    chk("coll_target", redirect_pc_o, 32'h0000_0200);
    rd(12'h340, 32'hF0F0_F000, "coll_mscratch");
    rd(12'h341, 32'h0000_4000, "coll_mepc");
    rd(12'h300, 32'h0000_1880, "coll_mstatus");
    rst_n = 1'b0;
    #1;
    chk("async_rst_redirect", {31'b0, redirect_o}, 32'h0);
    chk("async_rst_pc", redirect_pc_o, 32'h0);
    rd(12'h340, 32'h0, "async_rst_mscratch");
    tick();
    rst_n = 1'b1;
    tick();

`ifdef CSR_COUNTERS_EN
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_wr_lo");
    rd(12'hB80, 32'h0, "mcycle_wr_hi");
    tick();
    rd(12'hB00, 32'h0, "mcycle_carry_lo");
    rd(12'hB80, 32'h1, "mcycle_carry_hi");
    rd(12'hC80, 32'h1, "cycleh_shadow");
    retire_i = 1'b1;
    tick(); tick(); tick();
    retire_i = 1'b0;
    tick();
    rd(12'hB02, 32'h3, "minstret");
    rd(12'hC02, 32'h3, "instret_shadow");
    rd(12'hB82, 32'h0, "minstreth");
`else
    rd(12'hB00, 32'h0, "no_counter_data");
    chk("no_counter_illegal", {31'b0, rd_illegal_o}, 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
